// File: rtl/aes128_cbc_enc_chain_if.sv
// Plaintext, core and ciphertext signals of the CBC encrypt chaining controller.
// slave is the controller's view; master is the view of the environment around it.
interface aes128_cbc_enc_chain_if;
  logic [127:0] iv;
  logic         iv_load;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         pt_last;
  logic         core_start;
  logic [127:0] core_block;
  logic         core_done;
  logic [127:0] core_result;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         ct_last;
  logic         busy;
  logic         err;
  logic         err_clr;

  modport slave (
    input  iv, iv_load, pt_valid, pt_data, pt_last, core_done, core_result, ct_ready, err_clr,
    output pt_ready, core_start, core_block, ct_valid, ct_data, ct_last, busy, err
  );

  modport master (
    output iv, iv_load, pt_valid, pt_data, pt_last, core_done, core_result, ct_ready, err_clr,
    input  pt_ready, core_start, core_block, ct_valid, ct_data, ct_last, busy, err
  );
endinterface

// File: rtl/aes128_cbc_enc_chain.sv
// CBC encrypt chaining: XORs each plaintext block with the chain value, runs it through an
// external AES core via start/done, and streams the ciphertext out one block at a time.
module aes128_cbc_enc_chain #(
  parameter int CORE_TIMEOUT = 64,
  parameter int TMR_W        = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  aes128_cbc_enc_chain_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t             r_state, w_next;
  logic [127:0]       r_iv, r_chain, r_core_block, r_ct_data;
  logic               r_iv_vld, r_last, r_ct_last, r_err;
  logic [TMR_W-1:0]   r_timer;
  logic               w_pt_ready, w_accept, w_timeout;

  assign w_pt_ready = (r_state == S_IDLE) & r_iv_vld & ~bus.iv_load;
  assign w_accept   = bus.pt_valid & w_pt_ready;
  // done on the last allowed cycle still counts as success
  assign w_timeout  = (r_state == S_WAIT) & ~bus.core_done &
                      (r_timer == TMR_W'(CORE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (bus.core_done || w_timeout) w_next = bus.core_done ? S_OUT : S_IDLE;
      S_OUT:   if (bus.ct_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iv         <= '0;
      r_chain      <= '0;
      r_core_block <= '0;
      r_ct_data    <= '0;
      r_iv_vld     <= 1'b0;
      r_last       <= 1'b0;
      r_ct_last    <= 1'b0;
      r_err        <= 1'b0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.iv_load) begin
            r_iv     <= bus.iv;
            r_chain  <= bus.iv;
            r_iv_vld <= 1'b1;
          end else if (w_accept) begin
            r_core_block <= bus.pt_data ^ r_chain;
            r_last       <= bus.pt_last;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (bus.core_done) begin
            r_ct_data <= bus.core_result;
            r_chain   <= bus.core_result;
            r_ct_last <= r_last;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_timeout) r_chain <= r_iv;
          end
        end
        S_OUT: if (bus.ct_ready && r_ct_last) r_chain <= r_iv;
        default: ;
      endcase
      // a timeout in the same cycle as err_clr leaves the flag set
      if (w_timeout)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
    end
  end

  assign bus.pt_ready   = w_pt_ready;
  assign bus.core_start = (r_state == S_ISSUE);
  assign bus.core_block = r_core_block;
  assign bus.ct_valid   = (r_state == S_OUT);
  assign bus.ct_data    = r_ct_data;
  assign bus.ct_last    = r_ct_last;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err        = r_err;
endmodule

// File: tb/tb_aes128_cbc_enc_chain.sv
// Directed bench for the CBC encrypt chaining controller; the bench plays the AES core with
// fixed NIST SP800-38A ciphertexts and chosen latencies.
module tb_aes128_cbc_enc_chain;
  localparam int TO = 64;

  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] PT4 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] CB1 = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CB2 = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CB3 = 128'h30c91e45a759e216edf2cb1216075ce0;
  localparam logic [127:0] R3  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] CB4 = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] CB6 = 128'h6bd09cd16a15f9e161a4d4aabf4ef9d5;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  aes128_cbc_enc_chain_if bus();

  aes128_cbc_enc_chain #(.CORE_TIMEOUT(TO), .TMR_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // called at a negedge; lat = cycles from core_start to core_done
  task automatic run_block(input logic [127:0] pt, input logic last, input logic [127:0] exp_cb,
                           input int lat, input logic [127:0] res, input int stall);
    int n;
    bus.pt_data = pt; bus.pt_last = last; bus.pt_valid = 1'b1;
    #1;
    n = 0;
    while (bus.pt_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("pt_ready", bus.pt_ready, 1'b1);
    @(negedge clk);
    bus.pt_valid = 1'b0;
    chk("core_start", bus.core_start, 1'b1);
    chk("core_block", bus.core_block, exp_cb);
    @(negedge clk);
    chk("core_start_pulse", bus.core_start, 1'b0);
    repeat (lat - 1) @(negedge clk);
    chk("core_block_hold", bus.core_block, exp_cb);
    bus.core_result = res; bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0; bus.core_result = JUNK;
    chk("ct_valid", bus.ct_valid, 1'b1);
    chk("ct_data", bus.ct_data, res);
    chk("ct_last", bus.ct_last, last);
    for (int s = 0; s < stall; s++) begin
      bus.iv = JUNK; bus.iv_load = 1'b1;
      #1;
      chk("stall_ct_valid", bus.ct_valid, 1'b1);
      chk("stall_ct_data", bus.ct_data, res);
      chk("stall_pt_ready", bus.pt_ready, 1'b0);
      @(negedge clk);
    end
    bus.iv_load = 1'b0;
    bus.ct_ready = 1'b1;
    @(negedge clk);
    bus.ct_ready = 1'b0;
    chk("ct_valid_drop", bus.ct_valid, 1'b0);
    chk("busy_idle", bus.busy, 1'b0);
  endtask

  task automatic run_timeout(input logic [127:0] pt, input logic [127:0] exp_cb);
    bus.pt_data = pt; bus.pt_last = 1'b0; bus.pt_valid = 1'b1;
    #1;
    chk("to_pt_ready", bus.pt_ready, 1'b1);
    @(negedge clk);
    bus.pt_valid = 1'b0;
    chk("to_core_start", bus.core_start, 1'b1);
    chk("to_core_block", bus.core_block, exp_cb);
    // the last cycle a done would be honoured is core_start + TO
    repeat (TO) @(negedge clk);
    chk("to_err_early", bus.err, 1'b0);
    chk("to_busy_early", bus.busy, 1'b1);
    @(negedge clk);
    chk("to_err", bus.err, 1'b1);
    chk("to_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.iv = '0; bus.iv_load = 1'b0; bus.pt_valid = 1'b0; bus.pt_data = '0; bus.pt_last = 1'b0;
    bus.core_done = 1'b0; bus.core_result = '0; bus.ct_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pt_ready", bus.pt_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_ct_valid", bus.ct_valid, 1'b0);
    chk("rst_core_start", bus.core_start, 1'b0);
    chk("rst_ct_data", bus.ct_data, '0);
    chk("rst_core_block", bus.core_block, '0);
    chk("rst_ct_last", bus.ct_last, 1'b0);
    reset = 1'b1;

    // no IV yet: nothing is accepted
    bus.pt_valid = 1'b1; bus.pt_data = PT1;
    repeat (2) @(negedge clk);
    chk("noiv_pt_ready", bus.pt_ready, 1'b0);
    chk("noiv_busy", bus.busy, 1'b0);
    bus.pt_valid = 1'b0;
    bus.iv = JUNK; bus.iv_load = 1'b1;
    @(negedge clk);
    // IV reload with a same-cycle plaintext: the load wins, block goes next cycle with new IV
    bus.iv = IV1; bus.iv_load = 1'b1; bus.pt_valid = 1'b1;
    #1;
    chk("ivld_pt_ready", bus.pt_ready, 1'b0);
    @(negedge clk);
    bus.iv_load = 1'b0;
    chk("ivld_busy", bus.busy, 1'b0);
    run_block(PT1, 1'b0, CB1, 2, CT1, 0);

    // stray done in IDLE must not touch the chain
    bus.core_result = JUNK; bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("stray_busy", bus.busy, 1'b0);
    chk("stray_ct_valid", bus.ct_valid, 1'b0);

    run_block(PT2, 1'b1, CB2, 10, CT2, 5);
    run_block(PT3, 1'b0, CB3, 3, R3, 0);
    run_timeout(PT4, CB4);
    run_block(PT1, 1'b0, CB1, 2, CT1, 0);
    chk("err_sticky", bus.err, 1'b1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_clr", bus.err, 1'b0);
    // done on the final allowed cycle: success, no error
    run_block(PT2, 1'b1, CB2, TO, CT2, 0);
    chk("edge_err", bus.err, 1'b0);

    // reset while waiting on the core
    bus.pt_data = PT3; bus.pt_last = 1'b0; bus.pt_valid = 1'b1;
    @(negedge clk);
    bus.pt_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_core_block", bus.core_block, '0);
    chk("mid_rst_ct_data", bus.ct_data, '0);
    chk("mid_rst_ct_last", bus.ct_last, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.pt_valid = 1'b1; bus.pt_data = PT1;
    repeat (2) @(negedge clk);
    chk("post_rst_pt_ready", bus.pt_ready, 1'b0);
    bus.pt_valid = 1'b0;
    bus.iv = IV2; bus.iv_load = 1'b1;
    @(negedge clk);
    bus.iv_load = 1'b0;
    run_block(PT1, 1'b1, CB6, 2, CT1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
